// File: rtl/cascade_counter_n.sv
// Single-clock cascaded digit counter (up to 4 stages) with enable, up/down,
// clamped parallel load and registered wrap pulse. Define CASCADE_CNT_SATURATE_EN to hold at terminal state.
module cascade_counter_n #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MOD0   = 10,
  parameter int unsigned MOD1   = 6,
  parameter int unsigned MOD2   = 10,
  parameter int unsigned MOD3   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [STAGES*W-1:0]   load_val,
  output logic [STAGES*W-1:0]   cnt,
  output logic [STAGES-1:0]     stage_carry,
  output logic                  cout
);

  localparam int unsigned CW = STAGES * W;

  function automatic logic [W-1:0] digit_max(input int unsigned i);
    int unsigned m;
    case (i)
      0:       m = MOD0;
      1:       m = MOD1;
      2:       m = MOD2;
      default: m = MOD3;
    endcase
    return W'(m - 1);
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cout_q, cout_d;
  logic [STAGES-1:0] at_edge_c, step_c, wrap_c;
  logic              terminal_c, hold_c;

  // Carry chain: a stage steps when every lower stage sits at its wrap edge.
  always_comb begin
    logic run;
    at_edge_c = '0;
    step_c    = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      at_edge_c[i] = up ? (cnt_q[i*W +: W] == digit_max(i)) : (cnt_q[i*W +: W] == '0);
    end
    terminal_c = &at_edge_c;
`ifdef CASCADE_CNT_SATURATE_EN
    hold_c = terminal_c;
`else
    hold_c = 1'b0;
`endif
    run = en && !hold_c;
    for (int i = 0; i < int'(STAGES); i++) begin
      step_c[i] = run;
      run       = run && at_edge_c[i];
    end
    wrap_c = step_c & at_edge_c;
  end

  // Next state: load (with per-digit clamp) beats counting.
  always_comb begin
    logic [W-1:0] digit;
    cnt_d  = cnt_q;
    cout_d = 1'b0;
    digit  = '0;
    if (load) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        digit = load_val[i*W +: W];
        cnt_d[i*W +: W] = (digit > digit_max(i)) ? digit_max(i) : digit;
      end
    end else if (en) begin
      cout_d = terminal_c;
      for (int i = 0; i < int'(STAGES); i++) begin
        if (step_c[i]) begin
          if (up) begin
            cnt_d[i*W +: W] = at_edge_c[i] ? '0 : cnt_q[i*W +: W] + W'(1);
          end else begin
            cnt_d[i*W +: W] = at_edge_c[i] ? digit_max(i) : cnt_q[i*W +: W] - W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
    end
  end

  assign cnt         = cnt_q;
  assign cout        = cout_q;
  assign stage_carry = wrap_c;

endmodule

// File: tb/tb_cascade_counter_n.sv
// Scoreboard bench for cascade_counter_n: default mod-60 instance plus a 3-stage mod-1440 instance.
module tb_cascade_counter_n;

`ifdef CASCADE_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [7:0] load_val, cnt;
  logic [1:0] stage_carry;
  logic       cout;

  cascade_counter_n u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt), .stage_carry(stage_carry), .cout(cout)
  );

  logic        rst3, en3, up3, load3;
  logic [14:0] lv3, cnt3;
  logic [2:0]  sc3;
  logic        cout3;

  cascade_counter_n #(.W(5), .STAGES(3), .MOD0(10), .MOD1(6), .MOD2(24)) u_dut3 (
    .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3),
    .load_val(lv3), .cnt(cnt3), .stage_carry(sc3), .cout(cout3)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       cout;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mval = 0;
  logic mcout = 1'b0;
  int   cout_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Model keeps the count as a single integer 0..59 and splits it only for comparison.
  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [7:0] lv, input string tag);
    exp_t ex;
    int   d0, d1;
    logic term;
    logic [1:0] sc;
    rst = r; load = l; en = e; up = u; load_val = lv;
    #1;
    d0   = mval % 10;
    d1   = mval / 10;
    term = u ? (mval == 59) : (mval == 0);
    sc[0] = e && (u ? (d0 == 9) : (d0 == 0));
    sc[1] = sc[0] && (u ? (d1 == 5) : (d1 == 0));
    if (SAT && term) sc = 2'b00;
    check({tag, "_carry"}, 32'(stage_carry), 32'(sc));
    if (r) begin
      mval = 0; mcout = 1'b0;
    end else if (l) begin
      d0 = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
      d1 = (int'(lv[7:4]) > 5) ? 5 : int'(lv[7:4]);
      mval = d1 * 10 + d0; mcout = 1'b0;
    end else if (e) begin
      mcout = term;
      if (!(SAT && term)) mval = u ? (mval + 1) % 60 : (mval + 59) % 60;
    end else begin
      mcout = 1'b0;
    end
    ex.cnt = to_bcd(mval); ex.cout = mcout;
    sb_q.push_back(ex);
    @(posedge clk); #1;
    ex = sb_q.pop_front();
    check({tag, "_cnt"}, 32'(cnt), 32'(ex.cnt));
    check({tag, "_cout"}, 32'(cout), 32'(ex.cout));
    if (cout === 1'b1) cout_seen++;
  endtask

  initial begin
    logic [14:0] exp3;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    rst3 = 1'b1; en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; lv3 = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "reset");

    cout_seen = 0;
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "count60");
    check("count60_final", 32'(cnt), SAT ? 32'h59 : 32'h00);
    check("count60_pulses", 32'(cout_seen), 32'd1);

    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h7C, "load_clamp");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "clamp_wrap");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "clamp_idle");

    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, "load10");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "down09");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "down08");
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "load00");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "down_wrap");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "down_idle");

    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, "load08");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "gate_en1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "gate_en0");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "gate_en1b");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h34, "rst_over_load");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h34, "load_over_en");

    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h58, "sat_load58");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "sat_run");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "sat_en0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h59, "dir_load59");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "dir_term");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dir_away");

    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom), "rand");
    end

    exp3 = {5'd23, 5'd5, 5'd9};
    rst3 = 1'b0; load3 = 1'b1; lv3 = exp3;
    @(posedge clk); #1;
    check("s3_load_cnt", 32'(cnt3), 32'(exp3));
    check("s3_load_cout", 32'(cout3), 32'd0);
    load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    #1;
    check("s3_carry", 32'(sc3), SAT ? 32'd0 : 32'd7);
    @(posedge clk); #1;
    check("s3_wrap_cnt", 32'(cnt3), SAT ? 32'(exp3) : 32'd0);
    check("s3_wrap_cout", 32'(cout3), 32'd1);
    en3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
